// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the nRisc datapath: sequences fetch, decode, execute,
// memory and write-back, with a bounded memory handshake, sticky trap and retire counter.
module controle_multiciclo #(
   parameter int unsigned OPW         = 8,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CW          = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] instru,
   input  logic           zero,
   input  logic           memoPronta,
   output logic           escrita,
   output logic           ulaFonte,
   output logic           ulaOP,
   output logic           pula,
   output logic           regFonte,
   output logic           comparador,
   output logic           lerMemo,
   output logic           escreveMemo,
   output logic           escritaPC,
   output logic           escritaIR,
   output logic           erro,
   output logic [2:0]     estado,
   output logic [CW-1:0]  contInstr
);

   localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
   localparam logic [OPW-1:0] OP_JUMP  = OPW'(3);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
   localparam logic [OPW-1:0] OP_CMP   = OPW'(5);
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(6);
   localparam logic [OPW-1:0] OP_STORE = OPW'(7);
   localparam logic [OPW-1:0] OP_NOP   = OPW'(8);

   typedef enum logic [2:0] {
      BUSCA   = 3'd0,
      DECODE  = 3'd1,
      EXEC    = 3'd2,
      MEM     = 3'd3,
      ESCREVE = 3'd4,
      ERRO    = 3'd5
   } estado_t;

   estado_t        estado_q, estado_d;
   logic [OPW-1:0] op_q, op_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [CW-1:0]  cont_q, cont_d;
   logic           erro_q, erro_d;
   logic           retire;

   // State and bookkeeping registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= BUSCA;
         op_q     <= '0;
         tmo_q    <= '0;
         cont_q   <= '0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         op_q     <= op_d;
         tmo_q    <= tmo_d;
         cont_q   <= cont_d;
         erro_q   <= erro_d;
      end
   end

   // Next-state and strobe decode from the current state and latched opcode
   always_comb begin
      estado_d    = estado_q;
      op_d        = op_q;
      tmo_d       = tmo_q;
      retire      = 1'b0;
      escrita     = 1'b0;
      ulaFonte    = 1'b0;
      ulaOP       = 1'b0;
      pula        = 1'b0;
      regFonte    = 1'b0;
      comparador  = 1'b0;
      lerMemo     = 1'b0;
      escreveMemo = 1'b0;
      escritaPC   = 1'b0;
      escritaIR   = 1'b0;

      case (estado_q)
         BUSCA: begin
            escritaIR = 1'b1;
            escritaPC = 1'b1;
            estado_d  = DECODE;
         end
         DECODE: begin
            op_d     = instru;
            estado_d = (instru <= OP_NOP) ? EXEC : ERRO;
         end
         EXEC: begin
            tmo_d = '0;
            case (op_q)
               OP_ADD:  estado_d = ESCREVE;
               OP_ADDI: begin ulaFonte = 1'b1; estado_d = ESCREVE; end
               OP_SUB:  begin ulaOP = 1'b1; estado_d = ESCREVE; end
               OP_JUMP: begin
                  pula      = 1'b1;
                  escritaPC = 1'b1;
                  estado_d  = BUSCA;
                  retire    = 1'b1;
               end
               OP_BEQ: begin
                  comparador = 1'b1;
                  pula       = zero;
                  escritaPC  = zero;
                  estado_d   = BUSCA;
                  retire     = 1'b1;
               end
               OP_CMP:  begin comparador = 1'b1; estado_d = ESCREVE; end
               OP_LOAD, OP_STORE: begin ulaFonte = 1'b1; estado_d = MEM; end
               OP_NOP:  begin estado_d = BUSCA; retire = 1'b1; end
               default: estado_d = ERRO;
            endcase
         end
         MEM: begin
            ulaFonte    = 1'b1;
            lerMemo     = (op_q == OP_LOAD);
            escreveMemo = (op_q == OP_STORE);
            tmo_d       = tmo_q + TW'(1);
            // A ready on the last permitted cycle takes priority over the timeout
            if (memoPronta) begin
               if (op_q == OP_LOAD) begin
                  estado_d = ESCREVE;
               end else begin
                  estado_d = BUSCA;
                  retire   = 1'b1;
               end
            end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
               estado_d = ERRO;
            end
         end
         ESCREVE: begin
            escrita  = 1'b1;
            regFonte = (op_q == OP_LOAD);
            ulaOP    = (op_q == OP_SUB);
            ulaFonte = (op_q == OP_ADDI);
            estado_d = BUSCA;
            retire   = 1'b1;
         end
         ERRO:    estado_d = ERRO;
         default: estado_d = ERRO;
      endcase

      // Strobes are held low for the whole reset pulse, not just after the edge
      if (reset) begin
         escrita     = 1'b0;
         ulaFonte    = 1'b0;
         ulaOP       = 1'b0;
         pula        = 1'b0;
         regFonte    = 1'b0;
         comparador  = 1'b0;
         lerMemo     = 1'b0;
         escreveMemo = 1'b0;
         escritaPC   = 1'b0;
         escritaIR   = 1'b0;
      end
   end

   assign cont_d    = retire ? cont_q + CW'(1) : cont_q;
   assign erro_d    = (estado_d == ERRO);
   assign erro      = erro_q;
   assign estado    = estado_q;
   assign contInstr = cont_q;

endmodule
